// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: turns set/clear request pulses into the 2-bit sr code for the
// SR flip-flop. Each command is held for HOLD_CYC cycles and followed by a
// LOCKOUT-cycle gap of sr=00. Requests seen while busy are queued one deep per
// kind. When set and clear are both requested, one is issued and the other is
// discarded. The code 11 is never produced.
module sr_cmd_gen #(
    parameter int HOLD_CYC = 2,   // 1..15
    parameter int LOCKOUT  = 4,   // 0..15, 0 = no gap
    parameter int PRIO_CLR = 1    // 1 = clear wins a conflict, 0 = set wins
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_req,
    input  logic       clr_req,
    output logic [1:0] sr,
    output logic       busy,
    output logic [7:0] cmd_cnt,
    output logic [7:0] conflict_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_LOCK  = 2'd2;

    localparam logic [1:0] SR_HOLD = 2'b00;
    localparam logic [1:0] SR_CLR  = 2'b01;
    localparam logic [1:0] SR_SET  = 2'b10;

    // Timers count down to zero; the state is left on the edge that sees zero.
    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYC - 1);
    localparam logic [3:0] LOCK_LOAD = (LOCKOUT > 0) ? 4'(LOCKOUT - 1) : 4'd0;
    localparam bit         NO_LOCK   = (LOCKOUT == 0);
    localparam bit         CLR_WINS  = (PRIO_CLR != 0);

    logic [1:0] state_q, state_d;
    logic [3:0] timer_q, timer_d;
    logic [1:0] sr_q, sr_d;
    logic       busy_q, busy_d;
    logic       pend_set_q, pend_set_d;
    logic       pend_clr_q, pend_clr_d;
    logic [7:0] cmd_cnt_q, cmd_cnt_d;
    logic [7:0] conf_cnt_q, conf_cnt_d;

    logic eff_set;
    logic eff_clr;
    logic conflict;
    logic win_clr;
    logic decide;

    assign eff_set  = set_req | pend_set_q;
    assign eff_clr  = clr_req | pend_clr_q;
    assign conflict = eff_set & eff_clr;
    assign win_clr  = eff_clr & (~eff_set | CLR_WINS);

    // Edges where a new command may be issued: plain IDLE, and the last edge
    // of a busy period, so back-to-back commands leave no extra idle cycle.
    always_comb begin
        decide = 1'b0;
        case (state_q)
            ST_IDLE:  decide = 1'b1;
            ST_DRIVE: decide = (timer_q == 4'd0) && NO_LOCK;
            ST_LOCK:  decide = (timer_q == 4'd0);
            default:  decide = 1'b1;
        endcase
    end

    // Next-state logic: issue/arbitrate on decision edges, otherwise queue
    // requests and run the hold/lockout timers.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        sr_d       = sr_q;
        pend_set_d = pend_set_q;
        pend_clr_d = pend_clr_q;
        cmd_cnt_d  = cmd_cnt_q;
        conf_cnt_d = conf_cnt_q;
        if (decide) begin
            // Whatever was pending is consumed here: either issued or, for
            // the losing side of a conflict, discarded.
            pend_set_d = 1'b0;
            pend_clr_d = 1'b0;
            if (eff_set || eff_clr) begin
                state_d   = ST_DRIVE;
                timer_d   = HOLD_LOAD;
                sr_d      = win_clr ? SR_CLR : SR_SET;
                cmd_cnt_d = cmd_cnt_q + 8'd1;
                if (conflict && (conf_cnt_q != 8'hFF)) begin
                    conf_cnt_d = conf_cnt_q + 8'd1;
                end
            end else begin
                state_d = ST_IDLE;
                timer_d = 4'd0;
                sr_d    = SR_HOLD;
            end
        end else begin
            pend_set_d = pend_set_q | set_req;
            pend_clr_d = pend_clr_q | clr_req;
            if ((state_q == ST_DRIVE) && (timer_q == 4'd0)) begin
                state_d = ST_LOCK;
                timer_d = LOCK_LOAD;
                sr_d    = SR_HOLD;
            end else begin
                timer_d = timer_q - 4'd1;
            end
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State registers; reset overrides everything including an active command.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            timer_q    <= 4'd0;
            sr_q       <= SR_HOLD;
            busy_q     <= 1'b0;
            pend_set_q <= 1'b0;
            pend_clr_q <= 1'b0;
            cmd_cnt_q  <= 8'd0;
            conf_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            sr_q       <= sr_d;
            busy_q     <= busy_d;
            pend_set_q <= pend_set_d;
            pend_clr_q <= pend_clr_d;
            cmd_cnt_q  <= cmd_cnt_d;
            conf_cnt_q <= conf_cnt_d;
        end
    end

    assign sr           = sr_q;
    assign busy         = busy_q;
    assign cmd_cnt      = cmd_cnt_q;
    assign conflict_cnt = conf_cnt_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Bench for sr_cmd_gen: two builds (default, and no-lockout/set-wins) share
// the same stimulus. A time-based reference model pushes expected commands
// into per-build queues; a monitor pops them as commands appear on sr.
module tb_sr_cmd_gen;

    typedef struct {
        int         edge_n;
        logic [1:0] code;
        int         cmd;
        int         conf;
    } exp_t;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       set_req = 1'b1;
    logic       clr_req = 1'b1;
    logic [1:0] sr_w   [2];
    logic       busy_w [2];
    logic [7:0] cmd_w  [2];
    logic [7:0] conf_w [2];

    int tests  = 0;
    int fails  = 0;
    int edge_n = 0;

    int hold_p [2] = '{2, 2};
    int lock_p [2] = '{4, 0};
    int prio_p [2] = '{1, 0};

    // Reference model state: next cycle a command may issue, pending flags.
    exp_t       exp_q    [2][$];
    bit         pend_s   [2];
    bit         pend_c   [2];
    int         nf       [2];
    int         mcmd     [2];
    int         mconf    [2];
    bit         busy_exp [2];
    int         run_len  [2];
    logic [1:0] prev_sr  [2];

    sr_cmd_gen #(.HOLD_CYC(2), .LOCKOUT(4), .PRIO_CLR(1)) dut_a (
        .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req),
        .sr(sr_w[0]), .busy(busy_w[0]), .cmd_cnt(cmd_w[0]), .conflict_cnt(conf_w[0])
    );

    sr_cmd_gen #(.HOLD_CYC(2), .LOCKOUT(0), .PRIO_CLR(0)) dut_b (
        .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req),
        .sr(sr_w[1]), .busy(busy_w[1]), .cmd_cnt(cmd_w[1]), .conflict_cnt(conf_w[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(string nm, int act, int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    function automatic void model_step(int k, int e, bit s, bit c, bit r);
        bit   es;
        bit   ec;
        exp_t x;
        if (r) begin
            pend_s[k]   = 1'b0;
            pend_c[k]   = 1'b0;
            nf[k]       = 0;
            mcmd[k]     = 0;
            mconf[k]    = 0;
            busy_exp[k] = 1'b0;
        end else if (e >= nf[k]) begin
            es = s | pend_s[k];
            ec = c | pend_c[k];
            pend_s[k] = 1'b0;
            pend_c[k] = 1'b0;
            if (es || ec) begin
                if (es && ec) begin
                    x.code = (prio_p[k] != 0) ? 2'b01 : 2'b10;
                    if (mconf[k] < 255) mconf[k]++;
                end else begin
                    x.code = ec ? 2'b01 : 2'b10;
                end
                mcmd[k]  = (mcmd[k] + 1) % 256;
                nf[k]    = e + hold_p[k] + lock_p[k];
                x.edge_n = e;
                x.cmd    = mcmd[k];
                x.conf   = mconf[k];
                exp_q[k].push_back(x);
            end
            busy_exp[k] = (e < nf[k]);
        end else begin
            pend_s[k]   = pend_s[k] | s;
            pend_c[k]   = pend_c[k] | c;
            busy_exp[k] = 1'b1;
        end
    endfunction

    // Drive inputs for the next rising edge and advance the model for it.
    task automatic drive(bit s, bit c, bit r);
        @(negedge clk);
        set_req = s;
        clr_req = c;
        rst     = r;
        for (int k = 0; k < 2; k++) model_step(k, edge_n + 1, s, c, r);
    endtask

    task automatic mon_inst(int k, bit rst_s);
        logic [1:0] cur;
        bit         start;
        exp_t       x;
        cur = sr_w[k];
        chk($sformatf("busy[%0d] edge %0d", k, edge_n), int'(busy_w[k]), int'(busy_exp[k]));
        chk($sformatf("sr legal[%0d] edge %0d", k, edge_n), int'(cur == 2'b11), 0);
        start = (cur != 2'b00) && ((cur != prev_sr[k]) || (run_len[k] >= hold_p[k]));
        if ((prev_sr[k] != 2'b00) && ((cur == 2'b00) || start) && !rst_s)
            chk($sformatf("hold width[%0d] edge %0d", k, edge_n), run_len[k], hold_p[k]);
        if (start) begin
            if (exp_q[k].size() == 0) begin
                chk($sformatf("spurious cmd[%0d] edge %0d", k, edge_n), int'(cur), 0);
            end else begin
                x = exp_q[k].pop_front();
                chk($sformatf("cmd edge[%0d]", k), edge_n, x.edge_n);
                chk($sformatf("cmd code[%0d] edge %0d", k, edge_n), int'(cur), int'(x.code));
                chk($sformatf("cmd_cnt[%0d] edge %0d", k, edge_n), int'(cmd_w[k]), x.cmd);
                chk($sformatf("conflict_cnt[%0d] edge %0d", k, edge_n), int'(conf_w[k]), x.conf);
            end
        end else if ((exp_q[k].size() != 0) && (exp_q[k][0].edge_n <= edge_n)) begin
            x = exp_q[k].pop_front();
            tests++;
            fails++;
            $display("FAIL missed cmd[%0d]: sr=%0d at edge %0d, expected code %0d from edge %0d",
                     k, cur, edge_n, x.code, x.edge_n);
        end
        if (start)              run_len[k] = 1;
        else if (cur != 2'b00)  run_len[k] = run_len[k] + 1;
        else                    run_len[k] = 0;
        prev_sr[k] = cur;
    endtask

    always @(posedge clk) begin : monitor
        bit rst_s;
        rst_s = rst;
        #1;
        for (int k = 0; k < 2; k++) mon_inst(k, rst_s);
    end

    initial begin
        // Reset with both requests held high.
        repeat (2) drive(1'b1, 1'b1, 1'b1);
        repeat (4) drive(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset sr[%0d]", k), int'(sr_w[k]), 0);
            chk($sformatf("reset busy[%0d]", k), int'(busy_w[k]), 0);
            chk($sformatf("reset cmd_cnt[%0d]", k), int'(cmd_w[k]), 0);
            chk($sformatf("reset conflict_cnt[%0d]", k), int'(conf_w[k]), 0);
        end

        // Single set pulse.
        drive(1'b1, 1'b0, 1'b0);
        repeat (10) drive(1'b0, 1'b0, 1'b0);
        // Simultaneous set and clear.
        drive(1'b1, 1'b1, 1'b0);
        repeat (8) drive(1'b0, 1'b0, 1'b0);
        // Clear arriving during lockout.
        drive(1'b1, 1'b0, 1'b0);
        repeat (2) drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        repeat (10) drive(1'b0, 1'b0, 1'b0);
        // Set held high.
        repeat (20) drive(1'b1, 1'b0, 1'b0);
        repeat (10) drive(1'b0, 1'b0, 1'b0);
        // Reset in the middle of a command, with a clear request alongside.
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        repeat (8) drive(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++)
            chk($sformatf("cmd_cnt after mid-drive reset[%0d]", k), int'(cmd_w[k]), 0);

        // Random requests with occasional reset.
        repeat (1000)
            drive(bit'($urandom_range(0, 99) < 20), bit'($urandom_range(0, 99) < 20),
                  bit'($urandom_range(0, 299) == 0));
        repeat (10) drive(1'b0, 1'b0, 1'b0);

        // Both requests held: 300 commands on the default build, 898 on the
        // no-lockout build; every command is a conflict.
        drive(1'b0, 1'b0, 1'b1);
        repeat (1795) drive(1'b1, 1'b1, 1'b0);
        repeat (8) drive(1'b0, 1'b0, 1'b0);
        chk("cmd_cnt wrap a", int'(cmd_w[0]), 44);
        chk("conflict_cnt saturate a", int'(conf_w[0]), 255);
        chk("cmd_cnt wrap b", int'(cmd_w[1]), 130);
        chk("conflict_cnt saturate b", int'(conf_w[1]), 255);

        repeat (4) drive(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++)
            chk($sformatf("expected queue drained[%0d]", k), exp_q[k].size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
